// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the uart_tx byte scheduler.
// UART_SCHED_CHK_EN selects the 7-byte packet with a trailing XOR checksum.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_SEND,
    ST_GAP
  } state_t;

  typedef enum logic {
    GNT_COORD = 1'b0,
    GNT_THR   = 1'b1
  } grant_t;

  localparam logic [7:0] TYPE_COORD = 8'h01;
  localparam logic [7:0] TYPE_THR   = 8'h02;

`ifdef UART_SCHED_CHK_EN
  localparam int unsigned PKT_LEN = 7;
`else
  localparam int unsigned PKT_LEN = 6;
`endif

  localparam int unsigned IDX_W = 3;

  typedef struct packed {
    logic [7:0]  typ;
    logic [31:0] payload;
  } pkt_t;

`ifdef UART_SCHED_CHK_EN
  function automatic logic [7:0] pkt_chk(input pkt_t pkt);
    return pkt.typ ^ pkt.payload[31:24] ^ pkt.payload[23:16]
                   ^ pkt.payload[15:8]  ^ pkt.payload[7:0];
  endfunction
`endif

  // Byte at position idx of the framed packet; header is excluded from the checksum.
  function automatic logic [7:0] pkt_byte(input logic [IDX_W-1:0] idx,
                                          input logic [7:0]       hdr,
                                          input pkt_t             pkt);
    logic [7:0] b;
    case (idx)
      3'd0:    b = hdr;
      3'd1:    b = pkt.typ;
      3'd2:    b = pkt.payload[31:24];
      3'd3:    b = pkt.payload[23:16];
      3'd4:    b = pkt.payload[15:8];
      3'd5:    b = pkt.payload[7:0];
`ifdef UART_SCHED_CHK_EN
      3'd6:    b = pkt_chk(pkt);
`endif
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester handshakes and uart_tx byte channel of the scheduler.
interface uart_tx_sched_if;
  import uart_sched_pkg::*;

  logic        coord_req;
  logic [15:0] coord_x;
  logic [15:0] coord_y;
  logic        coord_ack;
  logic        thr_req;
  logic [31:0] thr_data;
  logic        thr_ack;
  logic [7:0]  tx_data;
  logic        tx_trig;
  logic        busy;

  modport master (
    output coord_req, coord_x, coord_y, thr_req, thr_data,
    input  coord_ack, thr_ack, tx_data, tx_trig, busy
  );

  modport slave (
    input  coord_req, coord_x, coord_y, thr_req, thr_data,
    output coord_ack, thr_ack, tx_data, tx_trig, busy
  );

endinterface

// File: rtl/uart_byte_pacer.sv
// Byte-slot gap counter: after a start pulse, done pulses in the last of SLOT_CYC-1 gap cycles.
module uart_byte_pacer #(
  parameter int unsigned SLOT_CYC = 57288
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam int unsigned CNT_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;

  logic [CNT_W-1:0] cnt;
  logic             run;

  // cnt holds the 1-based gap cycle index; it is only cleared by start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      done <= 1'b0;
      if (done) begin
        busy <= 1'b0;
      end
      if (start) begin
        cnt  <= CNT_W'(1);
        run  <= 1'b1;
        busy <= 1'b1;
      end else if (run) begin
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(SLOT_CYC - 2)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler framing coord/threshold reports onto the uart_tx byte channel.
// Optional UART_SCHED_CHK_EN appends an XOR checksum byte to every packet.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int unsigned UART_BPS = 9600,
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter logic [7:0]  HDR_BYTE = 8'hA5,
  parameter int unsigned GAP_BITS = 11
) (
  input logic             clk,
  input logic             rst,
  uart_tx_sched_if.slave  bus
);

  localparam int unsigned BIT_CYC  = CLK_FREQ / UART_BPS;
  localparam int unsigned SLOT_CYC = BIT_CYC * GAP_BITS;

  state_t              state;
  grant_t              last_grant;
  grant_t              winner_c;
  pkt_t                pkt;
  logic [IDX_W-1:0]    byte_idx;
  logic                pacer_start_c;
  logic                pacer_busy;
  logic                pacer_done;

  // Tie goes to whoever was not served last.
  always_comb begin
    winner_c = GNT_COORD;
    if (bus.coord_req && bus.thr_req) begin
      winner_c = (last_grant == GNT_THR) ? GNT_COORD : GNT_THR;
    end else if (bus.thr_req) begin
      winner_c = GNT_THR;
    end
  end

  assign pacer_start_c = (state == ST_SEND);

  uart_byte_pacer #(
    .SLOT_CYC (SLOT_CYC)
  ) u_pacer (
    .clk   (clk),
    .rst   (rst),
    .start (pacer_start_c),
    .busy  (pacer_busy),
    .done  (pacer_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      last_grant    <= GNT_THR;
      pkt           <= '0;
      byte_idx      <= '0;
      bus.coord_ack <= 1'b0;
      bus.thr_ack   <= 1'b0;
      bus.tx_data   <= 8'h00;
      bus.tx_trig   <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.coord_ack <= 1'b0;
      bus.thr_ack   <= 1'b0;
      bus.tx_trig   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.coord_req || bus.thr_req) begin
            state      <= ST_GRANT;
            bus.busy   <= 1'b1;
            byte_idx   <= '0;
            last_grant <= winner_c;
            if (winner_c == GNT_COORD) begin
              pkt.typ       <= TYPE_COORD;
              pkt.payload   <= {bus.coord_x, bus.coord_y};
              bus.coord_ack <= 1'b1;
            end else begin
              pkt.typ     <= TYPE_THR;
              pkt.payload <= bus.thr_data;
              bus.thr_ack <= 1'b1;
            end
          end
        end
        ST_GRANT: begin
          state       <= ST_SEND;
          bus.tx_trig <= 1'b1;
          bus.tx_data <= pkt_byte(byte_idx, HDR_BYTE, pkt);
        end
        ST_SEND: begin
          state <= ST_GAP;
        end
        ST_GAP: begin
          // A pacer that went idle without a done also closes the slot.
          if (pacer_done || !pacer_busy) begin
            if (byte_idx == IDX_W'(PKT_LEN - 1)) begin
              state    <= ST_IDLE;
              bus.busy <= 1'b0;
            end else begin
              state       <= ST_SEND;
              byte_idx    <= byte_idx + IDX_W'(1);
              bus.tx_trig <= 1'b1;
              bus.tx_data <= pkt_byte(byte_idx + IDX_W'(1), HDR_BYTE, pkt);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
